// File: rtl/glitch_gen.sv
// Serialiser for loopback and self-test. Holds each bit for HOLD clocks and can
// inject at most one short opposite-level glitch per symbol, placed by an LFSR.
module glitch_gen #(
   parameter int         HOLD       = 8,
   parameter int         GLITCH_MAX = 2,
   parameter logic [7:0] SEED       = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       bit_in,
   input  logic       bit_valid,
   output logic       bit_ready,
   input  logic       glitch_en,
   output logic       sig_out,
   output logic       busy,
   output logic [7:0] glitch_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_GLITCH
   } state_t;

   localparam logic [15:0] HOLD_LAST = 16'(HOLD - 1);

   state_t      state_q;
   logic        level_q;
   logic        sig_q;
   logic        done_q;
   logic [15:0] hold_q;
   logic [7:0]  gl_q;
   logic [7:0]  cnt_q;
   logic [7:0]  lfsr_q;
   logic [7:0]  lfsr_d;
   logic [7:0]  glWidth;
   logic        accept;
   logic        glitchStart;

   // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
   assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign glWidth = 8'((32'(lfsr_q[7:2]) % GLITCH_MAX) + 1);

   assign bit_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && (hold_q == 16'd0));
   assign accept    = bit_valid && bit_ready;

   // Leaving two spare clocks guarantees the level is restored before the symbol ends.
   assign glitchStart = glitch_en && (lfsr_q[1:0] == 2'b00) && !done_q &&
                        (hold_q >= ({8'd0, glWidth} + 16'd2));

   assign busy       = (state_q != ST_IDLE);
   assign sig_out    = sig_q;
   assign glitch_cnt = cnt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         level_q <= 1'b1;
         sig_q   <= 1'b1;
         done_q  <= 1'b0;
         hold_q  <= 16'd0;
         gl_q    <= 8'd0;
         cnt_q   <= 8'd0;
         lfsr_q  <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
         if (accept) begin
            level_q <= bit_in;
            sig_q   <= bit_in;
            hold_q  <= HOLD_LAST;
            done_q  <= 1'b0;
            state_q <= ST_HOLD;
         end else begin
            case (state_q)
               ST_HOLD: begin
                  if (hold_q == 16'd0) begin
                     state_q <= ST_IDLE;
                  end else begin
                     hold_q <= hold_q - 16'd1;
                     if (glitchStart) begin
                        sig_q   <= ~level_q;
                        gl_q    <= glWidth - 8'd1;
                        done_q  <= 1'b1;
                        state_q <= ST_GLITCH;
                        if (cnt_q != 8'hFF) begin
                           cnt_q <= cnt_q + 8'd1;
                        end
                     end
                  end
               end
               // The symbol clock keeps running underneath the glitch so boundaries never move.
               ST_GLITCH: begin
                  hold_q <= hold_q - 16'd1;
                  if (gl_q == 8'd0) begin
                     sig_q   <= level_q;
                     state_q <= ST_HOLD;
                  end else begin
                     gl_q <= gl_q - 8'd1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_glitch_gen.sv
// Directed bench for glitch_gen: a cycle model of the line, a window-3 loopback
// filter, reset/replay determinism and glitch counter saturation.
module tb_glitch_gen;

   localparam int HOLD  = 8;
   localparam int GMAX  = 2;
   localparam int HOLD2 = 5;
   localparam int GMAX2 = 1;

   logic       clock;
   logic       reset;
   logic       bitIn;
   logic       bitValid;
   logic       glitchEn;
   logic       bitReady;
   logic       sigOut;
   logic       busy;
   logic [7:0] glitchCnt;
   logic       bitReady2;
   logic       sigOut2;
   logic       busy2;
   logic [7:0] glitchCnt2;

   glitch_gen #(.HOLD(HOLD), .GLITCH_MAX(GMAX), .SEED(8'hA5)) dut (
      .clock(clock), .reset(reset), .bit_in(bitIn), .bit_valid(bitValid),
      .bit_ready(bitReady), .glitch_en(glitchEn), .sig_out(sigOut),
      .busy(busy), .glitch_cnt(glitchCnt)
   );

   glitch_gen #(.HOLD(HOLD2), .GLITCH_MAX(GMAX2), .SEED(8'hA5)) dutSat (
      .clock(clock), .reset(reset), .bit_in(bitIn), .bit_valid(bitValid),
      .bit_ready(bitReady2), .glitch_en(glitchEn), .sig_out(sigOut2),
      .busy(busy2), .glitch_cnt(glitchCnt2)
   );

   // Free-running 10-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard time limit so the bench can never hang.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached, observed running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   int errors   = 0;
   int checks   = 0;
   int traceErr = 0;

   bit         mBusy, mLevel, mSig, mDone;
   int         mPos, mGlRem, mCnt;
   logic [7:0] mLfsr;

   bit stream[$];
   bit traceSig[$];
   bit traceBusy[$];
   int excStarts[$];
   int posA[$];
   int excCount, maxRun, maxPerSym, filtErr;
   bit aborted;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      mBusy  = 1'b0;
      mLevel = 1'b1;
      mSig   = 1'b1;
      mDone  = 1'b0;
      mPos   = 0;
      mGlRem = 0;
      mCnt   = 0;
      mLfsr  = 8'hA5;
   endtask

   function automatic bit modelReady();
      return !mBusy || (mPos == HOLD - 1);
   endfunction

   // One clock of the line as described behaviourally: position within the symbol,
   // remaining glitch clocks and the one-glitch-per-symbol flag.
   task automatic modelStep();
      int w;
      w = (int'(mLfsr[7:2]) % GMAX) + 1;
      if (bitValid && modelReady()) begin
         mBusy  = 1'b1;
         mPos   = 0;
         mLevel = bitIn;
         mSig   = bitIn;
         mDone  = 1'b0;
         mGlRem = 0;
      end else if (mBusy) begin
         if (mGlRem > 0) begin
            mPos++;
            mGlRem--;
            if (mGlRem == 0) mSig = mLevel;
         end else if (mPos == HOLD - 1) begin
            mBusy = 1'b0;
         end else if (glitchEn && mLfsr[1:0] == 2'b00 && !mDone && (HOLD - 1 - mPos) >= w + 2) begin
            mSig   = ~mLevel;
            mGlRem = w;
            mDone  = 1'b1;
            if (mCnt < 255) mCnt++;
            mPos++;
         end else begin
            mPos++;
         end
      end
      mLfsr = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
   endtask

   // Advance one clock with the current inputs and compare the outputs to the model.
   task automatic applyStimulus();
      modelStep();
      @(posedge clock);
      #1;
      if (sigOut !== mSig || busy !== mBusy || bitReady !== modelReady() ||
          glitchCnt !== 8'(mCnt)) begin
         traceErr++;
      end
   endtask

   task automatic doReset();
      reset = 1'b0;
      resetModel();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   // Send the queued bits back to back from IDLE, gathering excursion and filter statistics.
   task automatic runStream(input int nsym, input bit abortInGlitch);
      int  runLen, symExc, fCnt, sym, pos;
      bit  exc, fOut;
      excStarts.delete();
      traceSig.delete();
      traceBusy.delete();
      excCount  = 0;
      maxRun    = 0;
      maxPerSym = 0;
      filtErr   = 0;
      aborted   = 1'b0;
      runLen    = 0;
      symExc    = 0;
      fCnt      = 0;
      fOut      = sigOut;
      bitValid  = 1'b1;
      for (int n = 0; n < nsym * HOLD; n++) begin
         sym   = n / HOLD;
         pos   = n % HOLD;
         bitIn = stream[sym];
         applyStimulus();
         traceSig.push_back(sigOut);
         traceBusy.push_back(busy);
         exc = (sigOut != stream[sym]);
         if (exc) begin
            if (runLen == 0) begin
               excCount++;
               symExc++;
               excStarts.push_back(n);
            end
            runLen++;
            if (runLen > maxRun) maxRun = runLen;
         end else begin
            runLen = 0;
         end
         if (sigOut == fOut) begin
            fCnt = 0;
         end else begin
            fCnt++;
            if (fCnt == 3) begin
               fOut = sigOut;
               fCnt = 0;
            end
         end
         if (pos == HOLD - 1) begin
            if (fOut != stream[sym]) filtErr++;
            if (symExc > maxPerSym) maxPerSym = symExc;
            symExc = 0;
         end
         if (abortInGlitch && exc && sigOut == 1'b0 && sym >= 1) begin
            aborted = 1'b1;
            break;
         end
      end
      bitValid = 1'b0;
   endtask

   initial begin
      int badToggle, busyCount, posErr, monoErr, stayErr, hitCycle;
      bit saw254, hit;
      logic [7:0] prevCnt;
      logic [15:0] pat4;

      reset    = 1'b1;
      bitIn    = 1'b0;
      bitValid = 1'b0;
      glitchEn = 1'b0;
      resetModel();
      #2 reset = 1'b0;
      #10;
      checkOutput("rst_sig", sigOut, 1);
      checkOutput("rst_ready", bitReady, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_cnt", glitchCnt, 0);
      @(posedge clock);
      #1 reset = 1'b1;

      $display("[TB] plain symbols 1,0,1,1");
      stream = '{1'b1, 1'b0, 1'b1, 1'b1};
      runStream(4, 1'b0);
      checkOutput("t2_len", traceSig.size(), 32);
      checkOutput("t2_s0", traceSig[0], 1);
      checkOutput("t2_s7", traceSig[7], 1);
      checkOutput("t2_s8", traceSig[8], 0);
      checkOutput("t2_s15", traceSig[15], 0);
      checkOutput("t2_s16", traceSig[16], 1);
      checkOutput("t2_s31", traceSig[31], 1);
      badToggle = 0;
      busyCount = 0;
      for (int i = 0; i < traceSig.size(); i++) begin
         if (traceBusy[i]) busyCount++;
         if (i > 0 && traceSig[i] != traceSig[i-1] && (i % HOLD) != 0) badToggle++;
      end
      checkOutput("t2_busyAll", busyCount, 32);
      checkOutput("t2_midToggle", badToggle, 0);
      applyStimulus();
      checkOutput("t2_busyEnd", busy, 0);

      $display("[TB] idle gap after a 0 symbol");
      stream = '{1'b0};
      runStream(1, 1'b0);
      repeat (5) applyStimulus();
      checkOutput("t5_busy", busy, 0);
      checkOutput("t5_hold", sigOut, 0);
      checkOutput("t5_ready", bitReady, 1);
      bitIn    = 1'b1;
      bitValid = 1'b1;
      applyStimulus();
      checkOutput("t5_acceptSig", sigOut, 1);
      checkOutput("t5_acceptBusy", busy, 1);
      bitValid = 1'b0;
      repeat (10) applyStimulus();

      $display("[TB] 200 random symbols with glitches");
      glitchEn = 1'b1;
      stream.delete();
      for (int i = 0; i < 200; i++) stream.push_back(1'($urandom_range(1, 0)));
      runStream(200, 1'b0);
      checkOutput("t3_someGlitch", int'(excCount > 0), 1);
      checkOutput("t3_widthOk", int'(maxRun <= GMAX), 1);
      checkOutput("t3_perSymbol", int'(maxPerSym <= 1), 1);
      checkOutput("t3_cntMatch", glitchCnt, excCount);
      checkOutput("t3_filter", filtErr, 0);
      checkOutput("t3_trace", traceErr, 0);

      $display("[TB] reset inside a glitch and replay");
      pat4 = 16'b1101_1110_1011_0111;
      stream.delete();
      for (int i = 0; i < 16; i++) stream.push_back(pat4[i]);
      doReset();
      runStream(16, 1'b0);
      posA = excStarts;
      checkOutput("t4_hasGlitch", int'(posA.size() > 0), 1);
      doReset();
      runStream(16, 1'b1);
      checkOutput("t4_inGlitch", aborted, 1);
      reset = 1'b0;
      resetModel();
      #1;
      checkOutput("t1_sig", sigOut, 1);
      checkOutput("t1_ready", bitReady, 1);
      checkOutput("t1_busy", busy, 0);
      checkOutput("t1_cnt", glitchCnt, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      runStream(16, 1'b0);
      checkOutput("t4_replayCount", excStarts.size(), posA.size());
      posErr = 0;
      for (int i = 0; i < posA.size() && i < excStarts.size(); i++) begin
         if (excStarts[i] != posA[i]) posErr++;
      end
      checkOutput("t4_replayPos", posErr, 0);

      $display("[TB] saturation with HOLD=5, GLITCH_MAX=1");
      doReset();
      monoErr  = 0;
      stayErr  = 0;
      saw254   = 1'b0;
      hit      = 1'b0;
      hitCycle = -1;
      prevCnt  = glitchCnt2;
      bitValid = 1'b1;
      for (int n = 0; n < 3000 * HOLD2; n++) begin
         bitIn = 1'($urandom_range(1, 0));
         @(posedge clock);
         #1;
         if (glitchCnt2 < prevCnt) monoErr++;
         if (hit && glitchCnt2 != 8'hFF) stayErr++;
         if (glitchCnt2 == 8'hFE) saw254 = 1'b1;
         if (!hit && glitchCnt2 == 8'hFF) begin
            hit      = 1'b1;
            hitCycle = n;
         end
         prevCnt = glitchCnt2;
      end
      bitValid = 1'b0;
      checkOutput("t6_final", glitchCnt2, 255);
      checkOutput("t6_saw254", saw254, 1);
      checkOutput("t6_earlyHit", int'(hit && hitCycle < 10000), 1);
      checkOutput("t6_monotonic", monoErr, 0);
      checkOutput("t6_stays", stayErr, 0);
      checkOutput("trace_all", traceErr, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
